// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
// Used by sync_fifo and sync_fifo_ram, and intended for the multi-channel variant.
package sync_fifo_pkg;

  localparam int unsigned DEF_DATASIZE = 32;
  localparam int unsigned DEF_DEPTH    = 128;
  localparam int unsigned DEF_ADDRBITS = 7;

  // Accepted operation in one cycle, encoded as {write, read}.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

  // Minimum number of address bits needed to index 'value' entries.
  function automatic int unsigned clog2_f(input int unsigned value);
    int unsigned result;
    int unsigned remaining;
    result    = 0;
    remaining = (value > 1) ? value - 1 : 0;
    while (remaining != 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // Pointer advance for a non-power-of-two ring: wraps from limit-1 to 0 by compare.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned limit);
    return (ptr == limit - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage for sync_fifo: synchronous write, read port
// registered by default and asynchronous when FIFO_FWFT_EN is defined.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int unsigned datasize = DEF_DATASIZE,
  parameter int unsigned depth    = DEF_DEPTH,
  parameter int unsigned addrbits = DEF_ADDRBITS
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [addrbits-1:0] wr_addr,
  input  logic [datasize-1:0] wr_data,
  input  logic                rd_en,
  input  logic [addrbits-1:0] rd_addr,
  output logic [datasize-1:0] rd_data
);

  logic [datasize-1:0] mem [depth];

  // NOTE: the array has no reset on purpose; a reset would turn it into
  // flops and the FIFO never reads a word it has not written first.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

`ifdef FIFO_FWFT_EN
  assign rd_data = mem[rd_addr];

  logic unused_fwft;
  assign unused_fwft = rd_en ^ rst;
`else
  // The output register is reset so dataOut starts at zero.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end
`endif

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with arbitrary depth, exact occupancy, thresholds and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is registered read data.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned datasize = DEF_DATASIZE,
  parameter int unsigned depth    = DEF_DEPTH,
  parameter int unsigned addrbits = DEF_ADDRBITS
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic [datasize-1:0] dataIn,
  input  logic                insert,
  input  logic                remove,
  input  logic                flush,
  input  logic [addrbits:0]   afull_th,
  input  logic [addrbits:0]   aempty_th,
  output logic [datasize-1:0] dataOut,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [addrbits:0]   count,
  output logic                overflow,
  output logic                underflow
);

  if (depth < 2 || clog2_f(depth) > addrbits) begin : g_bad_params
    $error("sync_fifo: depth must satisfy 2 <= depth <= 2**addrbits");
  end

  localparam logic [addrbits:0] CNT_ONE   = (addrbits + 1)'(1);
  localparam logic [addrbits:0] CNT_DEPTH = (addrbits + 1)'(depth);

  logic [addrbits-1:0] wraddr;
  logic [addrbits-1:0] rdaddr;
  logic [addrbits:0]   count_next;
  logic                wr_en;
  logic                rd_en;
  fifo_op_e            op;

  // Flush wins over both requests; a full FIFO never passes a write through.
  assign wr_en = insert && !full  && !flush;
  assign rd_en = remove && !empty && !flush;
  assign op    = fifo_op_e'({wr_en, rd_en});

  // NOTE: every path assigns count_next a default first so no latch is inferred.
  always_comb begin
    count_next = count;
    unique case (op)
      OP_WRITE: count_next = count + CNT_ONE;
      OP_READ:  count_next = count - CNT_ONE;
      default:  count_next = count;
    endcase
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      wraddr    <= '0;
      rdaddr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wraddr    <= '0;
      rdaddr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wraddr <= addrbits'(ptr_inc(32'(wraddr), depth));
      end
      if (rd_en) begin
        rdaddr <= addrbits'(ptr_inc(32'(rdaddr), depth));
      end
      count <= count_next;
      full  <= (count_next == CNT_DEPTH);
      empty <= (count_next == '0);
      if (insert && full) begin
        overflow <= 1'b1;
      end
      if (remove && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  // Thresholds are live inputs compared against the registered occupancy.
  assign almost_full  = (count >= afull_th);
  assign almost_empty = (count <= aempty_th);

  sync_fifo_ram #(
    .datasize (datasize),
    .depth    (depth),
    .addrbits (addrbits)
  ) u_ram (
    .clk_in  (clk_in),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wraddr),
    .wr_data (dataIn),
    .rd_en   (rd_en),
    .rd_addr (rdaddr),
    .rd_data (dataOut)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Randomised, self-checking bench for sync_fifo (depth 5, 3 address bits, 8-bit data)
// against a queue-based reference model, plus directed literal checks.
module tb_sync_fifo;

  localparam int DEPTH = 5;
  localparam int AW    = 3;
  localparam int DW    = 8;

  logic          clk_in = 1'b0;
  logic          rst    = 1'b0;
  logic [DW-1:0] dataIn = '0;
  logic          insert = 1'b0;
  logic          remove = 1'b0;
  logic          flush  = 1'b0;
  logic [AW:0]   afull_th  = 4'd4;
  logic [AW:0]   aempty_th = 4'd1;
  logic [DW-1:0] dataOut;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]   count;

  sync_fifo #(.datasize(DW), .depth(DEPTH), .addrbits(AW)) dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .dataIn       (dataIn),
    .insert       (insert),
    .remove       (remove),
    .flush        (flush),
    .afull_th     (afull_th),
    .aempty_th    (aempty_th),
    .dataOut      (dataOut),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Reference model: contents as a queue, sticky flags, last word read.
  logic [DW-1:0] model_q[$];
  bit            ovf_m = 1'b0;
  bit            unf_m = 1'b0;
  logic [DW-1:0] dout_m = '0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    ovf_m  = 1'b0;
    unf_m  = 1'b0;
    dout_m = '0;
  endtask

  task automatic model_edge();
    int sz;
    sz = model_q.size();
    if (flush) begin
      model_q.delete();
      ovf_m = 1'b0;
      unf_m = 1'b0;
    end else begin
      if (insert && sz == DEPTH) ovf_m = 1'b1;
      if (remove && sz == 0)     unf_m = 1'b1;
      if (remove && sz != 0)     dout_m = model_q.pop_front();
      if (insert && sz != DEPTH) model_q.push_back(dataIn);
    end
  endtask

  task automatic drive(input bit ins, input bit rem, input bit fl, input logic [DW-1:0] d);
    insert = ins;
    remove = rem;
    flush  = fl;
    dataIn = d;
  endtask

  // One clock: DUT and model both take the edge, then settle past the next negedge.
  task automatic step();
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
    #1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk_in) begin
    int sz;
    if (check_en) begin
      sz = model_q.size();
      check("count",        32'(count), 32'(sz));
      check("full",         32'(full), 32'(sz == DEPTH));
      check("empty",        32'(empty), 32'(sz == 0));
      check("almost_full",  32'(almost_full), 32'(sz >= int'(afull_th)));
      check("almost_empty", 32'(almost_empty), 32'(sz <= int'(aempty_th)));
      check("overflow",     32'(overflow), 32'(ovf_m));
      check("underflow",    32'(underflow), 32'(unf_m));
`ifdef FIFO_FWFT_EN
      if (sz > 0) check("dataOut_fwft", 32'(dataOut), 32'(model_q[0]));
`else
      check("dataOut", 32'(dataOut), 32'(dout_m));
`endif
    end
  end

  initial begin
    logic [DW-1:0] d;

    // Reset state
    @(negedge clk_in);
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_unf", 32'(underflow), 32'd0);
    check("rst_aempty", 32'(almost_empty), 32'd1);
    check("rst_afull", 32'(almost_full), 32'd0);
`ifndef FIFO_FWFT_EN
    check("rst_dataOut", 32'(dataOut), 32'd0);
`endif
    model_reset();
    rst = 1'b1;
    check_en = 1'b1;

    // Fill, then overflow
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'h11 + 8'(i);
      drive(1, 0, 0, d);
      step();
      check("fill_count", 32'(count), 32'(i + 1));
      check("fill_full", 32'(full), 32'(i == DEPTH - 1));
      check("fill_afull", 32'(almost_full), 32'(i + 1 >= 4));
    end
    drive(1, 0, 0, 8'h99);
    step();
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd5);

    // Drain, then underflow
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'h11 + 8'(i);
      drive(0, 1, 0, '0);
`ifdef FIFO_FWFT_EN
      check("drain_data_fwft", 32'(dataOut), 32'(d));
`endif
      step();
`ifndef FIFO_FWFT_EN
      check("drain_data", 32'(dataOut), 32'(d));
`endif
      check("drain_count", 32'(count), 32'(DEPTH - 1 - i));
      check("drain_aempty", 32'(almost_empty), 32'(DEPTH - 1 - i <= 1));
    end
    check("drain_empty", 32'(empty), 32'd1);
    drive(0, 1, 0, '0);
    step();
    check("unf_set", 32'(underflow), 32'd1);
`ifndef FIFO_FWFT_EN
    check("unf_data_hold", 32'(dataOut), 32'h15);
`endif

    // Wrap: simultaneous insert/remove at constant occupancy
    drive(1, 0, 0, 8'hA0); step();
    drive(1, 0, 0, 8'hA1); step();
    for (int i = 0; i < 12; i++) begin
`ifdef FIFO_FWFT_EN
      if (i == 0) check("wrap_first_fwft", 32'(dataOut), 32'hA0);
`endif
      drive(1, 1, 0, 8'($urandom));
      step();
`ifndef FIFO_FWFT_EN
      if (i == 0) check("wrap_first", 32'(dataOut), 32'hA0);
      if (i == 1) check("wrap_second", 32'(dataOut), 32'hA1);
`endif
      check("wrap_count", 32'(count), 32'd2);
    end

    // Unreachable almost-full threshold
    afull_th = 4'd7;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 8'($urandom));
      step();
      check("afull_never", 32'(almost_full), 32'd0);
    end
    afull_th = 4'd4;

    // Flush at count 3 with overflow set, together with an insert
    drive(0, 1, 0, '0); step();
    drive(0, 1, 0, '0); step();
    check("pre_flush_count", 32'(count), 32'd3);
    check("pre_flush_ovf", 32'(overflow), 32'd1);
    drive(1, 0, 1, 8'h77);
    step();
    check("flush_count", 32'(count), 32'd0);
    check("flush_empty", 32'(empty), 32'd1);
    check("flush_ovf", 32'(overflow), 32'd0);
    drive(0, 0, 0, '0);
    step();
    check("flush_ins_dropped", 32'(count), 32'd0);

    // Randomised traffic with biased phases and changing thresholds
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = ((i / 50) % 2 == 0) ? 70 : 30;
      if (i % 40 == 0) begin
        afull_th  = 4'($urandom_range(0, 7));
        aempty_th = 4'($urandom_range(0, 7));
      end
      drive($urandom_range(0, 99) < bias, $urandom_range(0, 99) < 100 - bias,
            $urandom_range(0, 59) == 0, 8'($urandom));
      step();
    end

    // Async reset mid-stream at count 4 with underflow set
    afull_th  = 4'd4;
    aempty_th = 4'd1;
    drive(0, 1, 1, '0); step();
    drive(0, 1, 0, '0); step();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 8'h30 + 8'(i));
      step();
    end
    drive(0, 0, 0, '0);
    check("pre_rst_count", 32'(count), 32'd4);
    check("pre_rst_unf", 32'(underflow), 32'd1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_full", 32'(full), 32'd0);
    check("arst_unf", 32'(underflow), 32'd0);
    check("arst_afull", 32'(almost_full), 32'd0);
    check("arst_aempty", 32'(almost_empty), 32'd1);
`ifndef FIFO_FWFT_EN
    check("arst_dataOut", 32'(dataOut), 32'd0);
`endif
    @(posedge clk_in);
    @(negedge clk_in);
    #1;
    rst = 1'b1;
    drive(1, 0, 0, 8'h5A);
    step();
    check("post_rst_count", 32'(count), 32'd1);
    check("post_rst_empty", 32'(empty), 32'd0);
`ifdef FIFO_FWFT_EN
    check("post_rst_data_fwft", 32'(dataOut), 32'h5A);
`else
    drive(0, 1, 0, '0);
    step();
    check("post_rst_data", 32'(dataOut), 32'h5A);
`endif
    drive(0, 0, 0, '0);
    step();

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
